condicionador_botoes: RTL and testbench

//  Upstream stage of the LED-matrix puzzle controller; drives its botoes[5:0] input.

---
 rtl/condicionador_botoes_if.sv | 29 ++
 rtl/condicionador_botoes.sv | 111 +++++++++++
 tb/tb_condicionador_botoes.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/condicionador_botoes_if.sv
// Button-conditioner bus: raw levels and enable in, debounced pulses and levels out.
// The slave modport is the conditioner; the master modport is whoever drives the buttons.
interface condicionador_botoes_if #(
  parameter int unsigned N_BOTOES = 6
) ();

  logic                habilitar;
  logic [N_BOTOES-1:0] botoes_brutos;
  logic [N_BOTOES-1:0] botoes_pulso;
  logic [N_BOTOES-1:0] botoes_estaveis;
  logic                algum_pulso;

  modport master (
    output habilitar,
    output botoes_brutos,
    input  botoes_pulso,
    input  botoes_estaveis,
    input  algum_pulso
  );

  modport slave (
    input  habilitar,
    input  botoes_brutos,
    output botoes_pulso,
    output botoes_estaveis,
    output algum_pulso
  );

endinterface

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: 2-FF synchroniser, per-button debounce FSM and counter,
// one registered pulse per accepted press, maskable by habilitar.
module condicionador_botoes #(
  parameter int unsigned N_BOTOES        = 6,
  parameter int unsigned DEBOUNCE_CICLOS = 500000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  condicionador_botoes_if.slave bus
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    StSolto,
    StConfirmaPress,
    StPressionado,
    StConfirmaSolta
  } estado_e;

  logic [N_BOTOES-1:0] sync1_q;
  logic [N_BOTOES-1:0] sync2_q;
  logic [N_BOTOES-1:0] pulso_vec;
  logic [N_BOTOES-1:0] estavel_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.botoes_brutos;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_botao
    estado_e         estado_q, estado_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            estavel_q, estavel_d;
    logic            pulso_q, pulso_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        estado_q  <= StSolto;
        cnt_q     <= '0;
        estavel_q <= 1'b0;
        pulso_q   <= 1'b0;
      end else begin
        estado_q  <= estado_d;
        cnt_q     <= cnt_d;
        estavel_q <= estavel_d;
        pulso_q   <= pulso_d;
      end
    end

    always_comb begin
      estado_d  = estado_q;
      cnt_d     = cnt_q;
      estavel_d = estavel_q;
      pulso_d   = 1'b0;
      unique case (estado_q)
        StSolto: begin
          if (sync2_q[i]) begin
            estado_d = StConfirmaPress;
            cnt_d    = '0;
          end
        end
        StConfirmaPress: begin
          if (!sync2_q[i]) begin
            estado_d = StSolto;
            cnt_d    = '0;
          end else if (cnt_q == CntMax) begin
            estado_d  = StPressionado;
            estavel_d = 1'b1;
            // A press accepted while masked is dropped, never queued.
            pulso_d   = bus.habilitar;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StPressionado: begin
          if (!sync2_q[i]) begin
            estado_d = StConfirmaSolta;
            cnt_d    = '0;
          end
        end
        StConfirmaSolta: begin
          if (sync2_q[i]) begin
            estado_d = StPressionado;
            cnt_d    = '0;
          end else if (cnt_q == CntMax) begin
            estado_d  = StSolto;
            estavel_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: estado_d = StSolto;
      endcase
    end

    assign pulso_vec[i]   = pulso_q;
    assign estavel_vec[i] = estavel_q;
  end

  assign bus.botoes_pulso    = pulso_vec;
  assign bus.botoes_estaveis = estavel_vec;
  assign bus.algum_pulso     = |pulso_vec;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Directed bench for condicionador_botoes with DEBOUNCE_CICLOS=4: a per-cycle vector
// table for clean and simultaneous presses, plus sequences for bounce, mask and reset.
module tb_condicionador_botoes;

  localparam int unsigned NB = 6;
  localparam int unsigned DB = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  condicionador_botoes_if #(.N_BOTOES(NB)) bus ();

  condicionador_botoes #(
    .N_BOTOES        (NB),
    .DEBOUNCE_CICLOS (DB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0] brutos;
    logic       hab;
    logic [5:0] pulso;
    logic [5:0] est;
    logic       algum;
  } vec_t;

  vec_t vec[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulse_cnt [NB];
  int pulse_cyc [NB];
  int est_rise  [NB];
  int est_fall  [NB];
  logic [NB-1:0] est_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] b, input logic h);
    bus.botoes_brutos = b;
    bus.habilitar     = h;
  endtask

  // Advance one clock, sample 1 time unit after the edge and accumulate statistics.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NB; i++) begin
      if (bus.botoes_pulso[i]) begin
        pulse_cnt[i]++;
        pulse_cyc[i] = cyc;
      end
      if (bus.botoes_estaveis[i] && !est_prev[i]) est_rise[i]++;
      if (!bus.botoes_estaveis[i] && est_prev[i]) est_fall[i]++;
    end
    est_prev = bus.botoes_estaveis;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NB; i++) begin
      pulse_cnt[i] = 0;
      pulse_cyc[i] = -1;
      est_rise[i]  = 0;
      est_fall[i]  = 0;
    end
    est_prev = bus.botoes_estaveis;
  endtask

  function automatic void row(input logic [5:0] b, input logic h, input logic [5:0] p,
                              input logic [5:0] e, input logic a);
    vec_t v;
    v.brutos = b; v.hab = h; v.pulso = p; v.est = e; v.algum = a;
    vec.push_back(v);
  endfunction

  int c0;
  int glitch_len [3] = '{3, 4, 5};
  int glitch_exp [3] = '{0, 0, 1};

  initial begin
    // Clean press of btn0: captured at row 0, pulse sampled at row 6, released at row 12.
    for (int j = 0; j < 6; j++) row(6'h01, 1'b1, 6'h00, 6'h00, 1'b0);
    row(6'h01, 1'b1, 6'h01, 6'h01, 1'b1);
    for (int j = 0; j < 5; j++) row(6'h01, 1'b1, 6'h00, 6'h01, 1'b0);
    for (int j = 0; j < 6; j++) row(6'h00, 1'b1, 6'h00, 6'h01, 1'b0);
    for (int j = 0; j < 2; j++) row(6'h00, 1'b1, 6'h00, 6'h00, 1'b0);
    // Simultaneous press of btn5 and btn0.
    for (int j = 0; j < 6; j++) row(6'h21, 1'b1, 6'h00, 6'h00, 1'b0);
    row(6'h21, 1'b1, 6'h21, 6'h21, 1'b1);
    row(6'h21, 1'b1, 6'h00, 6'h21, 1'b0);
    for (int j = 0; j < 6; j++) row(6'h00, 1'b1, 6'h00, 6'h21, 1'b0);
    for (int j = 0; j < 2; j++) row(6'h00, 1'b1, 6'h00, 6'h00, 1'b0);

    rst_n = 1'b0;
    drive(6'h00, 1'b1);
    clear_stats();
    tick();
    tick();
    chk("reset_pulso", bus.botoes_pulso, 6'h00);
    chk("reset_estaveis", bus.botoes_estaveis, 6'h00);
    chk("reset_algum", bus.algum_pulso, 1'b0);
    rst_n = 1'b1;

    for (int j = 0; j < vec.size(); j++) begin
      drive(vec[j].brutos, vec[j].hab);
      tick();
      chk($sformatf("tbl%0d_pulso", j), bus.botoes_pulso, vec[j].pulso);
      chk($sformatf("tbl%0d_estaveis", j), bus.botoes_estaveis, vec[j].est);
      chk($sformatf("tbl%0d_algum", j), bus.algum_pulso, vec[j].algum);
    end

    // Bounce on btn1: 1,0,1,0 then held; latency counts from the final rising capture.
    clear_stats();
    drive(6'h02, 1'b1); tick();
    drive(6'h00, 1'b1); tick();
    drive(6'h02, 1'b1); tick();
    drive(6'h00, 1'b1); tick();
    drive(6'h02, 1'b1); tick();
    c0 = cyc;
    repeat (14) tick();
    chk("bounce_npulse", pulse_cnt[1], 1);
    chk("bounce_latency", pulse_cyc[1], c0 + 6);
    chk("bounce_est_rise", est_rise[1], 1);
    chk("bounce_est_fall", est_fall[1], 0);
    chk("bounce_estaveis", bus.botoes_estaveis, 6'h02);
    drive(6'h00, 1'b1);
    repeat (10) tick();
    chk("bounce_release", bus.botoes_estaveis, 6'h00);

    // Short presses on btn2: 3 and 4 captured cycles are rejected, 5 is accepted.
    for (int g = 0; g < 3; g++) begin
      clear_stats();
      drive(6'h04, 1'b1);
      repeat (glitch_len[g]) tick();
      drive(6'h00, 1'b1);
      repeat (12) tick();
      chk($sformatf("glitch%0d_npulse", glitch_len[g]), pulse_cnt[2], glitch_exp[g]);
      chk($sformatf("glitch%0d_est_rise", glitch_len[g]), est_rise[2], glitch_exp[g]);
      chk($sformatf("glitch%0d_estaveis", glitch_len[g]), bus.botoes_estaveis, 6'h00);
    end

    // Mask on btn3: masked press dropped, unmasking while held does not pulse.
    clear_stats();
    drive(6'h08, 1'b0);
    repeat (10) tick();
    chk("mask_npulse", pulse_cnt[3], 0);
    chk("mask_estaveis", bus.botoes_estaveis, 6'h08);
    drive(6'h08, 1'b1);
    repeat (6) tick();
    chk("mask_unmask_npulse", pulse_cnt[3], 0);
    drive(6'h00, 1'b1);
    repeat (10) tick();
    chk("mask_release", bus.botoes_estaveis, 6'h00);
    drive(6'h08, 1'b1);
    repeat (10) tick();
    chk("mask_repress_npulse", pulse_cnt[3], 1);
    drive(6'h00, 1'b1);
    repeat (10) tick();

    // Reset mid-debounce: btn4 stable, btn5 two cycles into confirmation.
    clear_stats();
    drive(6'h10, 1'b1);
    repeat (10) tick();
    chk("rst_pre_estaveis", bus.botoes_estaveis, 6'h10);
    drive(6'h30, 1'b1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_async_estaveis", bus.botoes_estaveis, 6'h00);
    chk("rst_async_pulso", bus.botoes_pulso, 6'h00);
    chk("rst_async_algum", bus.algum_pulso, 1'b0);
    chk("rst_no_early_pulse", pulse_cnt[5], 0);
    tick();
    tick();
    rst_n = 1'b1;
    clear_stats();
    tick();
    c0 = cyc;
    repeat (12) tick();
    chk("rst_btn5_npulse", pulse_cnt[5], 1);
    chk("rst_btn5_latency", pulse_cyc[5], c0 + 6);
    chk("rst_btn4_npulse", pulse_cnt[4], 1);
    chk("rst_btn4_latency", pulse_cyc[4], c0 + 6);
    chk("rst_post_estaveis", bus.botoes_estaveis, 6'h30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
